// File: rtl/ahb_rom_slave_if_if.sv
// ---------------------------------------------------------------------------
// ahb_rom_slave_if_if
//   AHB-Lite bus bundle between the fabric and the instruction-ROM slave
//   front end.
//
//   Signals:
//     hsel      slave select from the address decoder
//     haddr     byte address (ADDR_W bits)
//     htrans    transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//     hwrite    1 = write
//     hsize     transfer size (only word is legal for the ROM)
//     hready    bus-wide HREADY
//     hrdata    read data back to the master (DATA_W bits)
//     hreadyout slave ready
//     hresp     0 OKAY, 1 ERROR
//
//   Modports: master drives the address phase, slave drives the response.
// ---------------------------------------------------------------------------
interface ahb_rom_slave_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic              hready;
    logic [DATA_W-1:0] hrdata;
    logic              hreadyout;
    logic              hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_rom_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_rom_slave_if
//   AHB-Lite slave front end for the instruction ROM. Decodes the address
//   phase, turns the byte address into a word index and sequences the ROM's
//   one-cycle registered read. Illegal transfers (writes, non-word sizes,
//   unaligned or out-of-range addresses) get a two-cycle ERROR response.
//
//   Ports:
//     clk          system clock, rising edge
//     reset        synchronous active-high reset
//     bus          AHB slave modport (hsel/haddr/htrans/hwrite/hsize/hready
//                  in, hrdata/hreadyout/hresp out)
//     sel_0        ROM select (registered)
//     rd_en_rom    ROM read enable (registered)
//     address_rom  ROM word index, haddr >> 2 (registered)
//     instr        ROM read data, valid one cycle after sel_0 && rd_en_rom
//     err_count    16-bit saturating count of ERROR responses started
//                  (present only when AHB_ROM_ERR_CNT_EN is defined)
//
//   Optional feature macro: AHB_ROM_ERR_CNT_EN
// ---------------------------------------------------------------------------
module ahb_rom_slave_if #(
    parameter int ROM_DEPTH = 5,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    ahb_rom_slave_if_if.slave    bus,
    output logic                 sel_0,
    output logic                 rd_en_rom,
    output logic [ADDR_W-1:0]    address_rom,
    input  logic [DATA_W-1:0]    instr
`ifdef AHB_ROM_ERR_CNT_EN
    ,
    output logic [15:0]          err_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_ERR1    = 3'd3,
        ST_ERR2    = 3'd4
    } state_t;

    localparam logic [2:0]        HSIZE_WORD = 3'b010;
    localparam logic [ADDR_W-3:0] DEPTH_IDX  = (ADDR_W-2)'(ROM_DEPTH);

    state_t            state_r;
    logic              hreadyout_r;
    logic              hresp_r;
    logic              sel_0_r;
    logic              rd_en_rom_r;
    logic [ADDR_W-1:0] address_rom_r;
    logic [DATA_W-1:0] hrdata_s;

    logic              accept_s;
    logic              legal_s;
    logic [ADDR_W-1:0] word_idx_s;
    // htrans[0] only separates IDLE/BUSY and NONSEQ/SEQ, which this slave
    // treats identically; kept here so it is visibly consumed.
    logic              unused_htrans0_s;

`ifdef AHB_ROM_ERR_CNT_EN
    logic [15:0]       err_count_r;
`endif

    assign unused_htrans0_s = bus.htrans[0];

    // Address-phase decode: acceptance, legality and the truncated word index.
    always_comb begin
        accept_s   = 1'b0;
        legal_s    = 1'b0;
        word_idx_s = {ADDR_W{1'b0}};
        if (bus.hsel && bus.hready && bus.htrans[1]) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (!bus.hwrite && (bus.hsize == HSIZE_WORD) &&
            (bus.haddr[1:0] == 2'b00) && (bus.haddr[ADDR_W-1:2] < DEPTH_IDX)) begin
            legal_s = 1'b1;
        end else begin
            legal_s = 1'b0;
        end
        word_idx_s = {2'b00, bus.haddr[ADDR_W-1:2]};
    end

    // Main FSM: state plus every registered bus and ROM control output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            hreadyout_r   <= 1'b1;
            hresp_r       <= 1'b0;
            sel_0_r       <= 1'b0;
            rd_en_rom_r   <= 1'b0;
            address_rom_r <= {ADDR_W{1'b0}};
`ifdef AHB_ROM_ERR_CNT_EN
            err_count_r   <= 16'd0;
`endif
        end else begin
            case (state_r)
                // The ROM latches instr at the end of this cycle; the
                // request is dropped on the same edge.
                ST_RD_WAIT: begin
                    state_r       <= ST_RD_DATA;
                    hreadyout_r   <= 1'b1;
                    hresp_r       <= 1'b0;
                    sel_0_r       <= 1'b0;
                    rd_en_rom_r   <= 1'b0;
                    address_rom_r <= {ADDR_W{1'b0}};
                end
                // First ERROR cycle always advances to the second.
                ST_ERR1: begin
                    state_r       <= ST_ERR2;
                    hreadyout_r   <= 1'b1;
                    hresp_r       <= 1'b1;
                    sel_0_r       <= 1'b0;
                    rd_en_rom_r   <= 1'b0;
                    address_rom_r <= {ADDR_W{1'b0}};
                end
                // States whose cycle can carry a new address phase.
                ST_IDLE, ST_RD_DATA, ST_ERR2: begin
                    if (accept_s && legal_s) begin
                        state_r       <= ST_RD_WAIT;
                        hreadyout_r   <= 1'b0;
                        hresp_r       <= 1'b0;
                        sel_0_r       <= 1'b1;
                        rd_en_rom_r   <= 1'b1;
                        address_rom_r <= word_idx_s;
                    end else if (accept_s) begin
                        state_r       <= ST_ERR1;
                        hreadyout_r   <= 1'b0;
                        hresp_r       <= 1'b1;
                        sel_0_r       <= 1'b0;
                        rd_en_rom_r   <= 1'b0;
                        address_rom_r <= {ADDR_W{1'b0}};
`ifdef AHB_ROM_ERR_CNT_EN
                        if (err_count_r != 16'hFFFF) begin
                            err_count_r <= err_count_r + 16'd1;
                        end else begin
                            err_count_r <= err_count_r;
                        end
`endif
                    end else if (!bus.hready) begin
                        // Another slave is stalling the bus: the current
                        // data phase (if any) is still being presented.
                        state_r       <= state_r;
                        hreadyout_r   <= hreadyout_r;
                        hresp_r       <= hresp_r;
                        sel_0_r       <= 1'b0;
                        rd_en_rom_r   <= 1'b0;
                        address_rom_r <= {ADDR_W{1'b0}};
                    end else begin
                        state_r       <= ST_IDLE;
                        hreadyout_r   <= 1'b1;
                        hresp_r       <= 1'b0;
                        sel_0_r       <= 1'b0;
                        rd_en_rom_r   <= 1'b0;
                        address_rom_r <= {ADDR_W{1'b0}};
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    hreadyout_r   <= 1'b1;
                    hresp_r       <= 1'b0;
                    sel_0_r       <= 1'b0;
                    rd_en_rom_r   <= 1'b0;
                    address_rom_r <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // Read data passes straight through from the ROM during the data phase
    // only; the ROM output register is already a flop, so no extra stage.
    always_comb begin
        hrdata_s = {DATA_W{1'b0}};
        if (state_r == ST_RD_DATA) begin
            hrdata_s = instr;
        end else begin
            hrdata_s = {DATA_W{1'b0}};
        end
    end

    assign bus.hrdata    = hrdata_s;
    assign bus.hreadyout = hreadyout_r;
    assign bus.hresp     = hresp_r;
    assign sel_0         = sel_0_r;
    assign rd_en_rom     = rd_en_rom_r;
    assign address_rom   = address_rom_r;

`ifdef AHB_ROM_ERR_CNT_EN
    assign err_count     = err_count_r;
`endif

endmodule

// File: tb/tb_ahb_rom_slave_if.sv
// ---------------------------------------------------------------------------
// tb_ahb_rom_slave_if
//   Directed self-checking bench for ahb_rom_slave_if with a small
//   registered ROM model (five words AAAA.., BBBB.., CCCC.., DDDD.., EEEE..).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_rom_slave_if;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              sel_0;
    logic              rd_en_rom;
    logic [ADDR_W-1:0] address_rom;
    logic [DATA_W-1:0] instr;
`ifdef AHB_ROM_ERR_CNT_EN
    logic [15:0]       err_count;
`endif

    int n_checks;
    int n_errors;

    logic [DATA_W-1:0] rom_mem [0:4];

    ahb_rom_slave_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ahb_rom_slave_if #(.ROM_DEPTH(5), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .sel_0       (sel_0),
        .rd_en_rom   (rd_en_rom),
        .address_rom (address_rom),
        .instr       (instr)
`ifdef AHB_ROM_ERR_CNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: one-cycle registered read.
    always @(posedge clk) begin
        if (sel_0 && rd_en_rom && (address_rom < 32'd5)) begin
            instr <= rom_mem[address_rom[2:0]];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hsel, input logic [1:0] htrans, input logic [31:0] haddr,
                         input logic hwrite, input logic [2:0] hsize, input logic hready);
        bus.hsel   = hsel;
        bus.htrans = htrans;
        bus.haddr  = haddr;
        bus.hwrite = hwrite;
        bus.hsize  = hsize;
        bus.hready = hready;
    endtask

    task automatic drive_idle();
        drive(1'b0, 2'b00, 32'h0, 1'b0, 3'b010, 1'b1);
    endtask

    // Single read transfer with a checked wait state and data phase.
    task automatic do_read(input string tag, input logic [31:0] haddr, input logic [31:0] exp_idx,
                           input logic [31:0] exp_data);
        drive(1'b1, 2'b10, haddr, 1'b0, 3'b010, 1'b1);
        step();
        drive_idle();
        check_val({tag, "_wait_rdy"}, {31'd0, bus.hreadyout}, 32'd0);
        check_val({tag, "_wait_rden"}, {31'd0, rd_en_rom}, 32'd1);
        check_val({tag, "_wait_addr"}, address_rom, exp_idx);
        step();
        check_val({tag, "_data_rdy"}, {31'd0, bus.hreadyout}, 32'd1);
        check_val({tag, "_data_resp"}, {31'd0, bus.hresp}, 32'd0);
        check_val({tag, "_data"}, bus.hrdata, exp_data);
        check_val({tag, "_data_rden"}, {31'd0, rd_en_rom}, 32'd0);
        step();
        check_val({tag, "_after"}, bus.hrdata, 32'd0);
    endtask

    // Illegal transfer: two ERROR cycles and no ROM access.
    task automatic do_err(input string tag, input logic [31:0] haddr, input logic hwrite,
                          input logic [2:0] hsize);
        drive(1'b1, 2'b10, haddr, hwrite, hsize, 1'b1);
        step();
        drive_idle();
        check_val({tag, "_e1_rdy"}, {31'd0, bus.hreadyout}, 32'd0);
        check_val({tag, "_e1_resp"}, {31'd0, bus.hresp}, 32'd1);
        check_val({tag, "_e1_rden"}, {31'd0, rd_en_rom}, 32'd0);
        step();
        check_val({tag, "_e2_rdy"}, {31'd0, bus.hreadyout}, 32'd1);
        check_val({tag, "_e2_resp"}, {31'd0, bus.hresp}, 32'd1);
        check_val({tag, "_e2_rden"}, {31'd0, rd_en_rom}, 32'd0);
        step();
        check_val({tag, "_done_resp"}, {31'd0, bus.hresp}, 32'd0);
    endtask

    // Transfers that must see a zero-wait OKAY and no ROM activity.
    task automatic do_okay(input string tag, input logic hsel, input logic [1:0] htrans);
        drive(hsel, htrans, 32'h4, 1'b0, 3'b010, 1'b1);
        step();
        check_val({tag, "_rdy"}, {31'd0, bus.hreadyout}, 32'd1);
        check_val({tag, "_resp"}, {31'd0, bus.hresp}, 32'd0);
        check_val({tag, "_data"}, bus.hrdata, 32'd0);
        check_val({tag, "_rom"}, {30'd0, sel_0, rd_en_rom}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rom_mem[0] = 32'hAAAA_AAAA;
        rom_mem[1] = 32'hBBBB_BBBB;
        rom_mem[2] = 32'hCCCC_CCCC;
        rom_mem[3] = 32'hDDDD_DDDD;
        rom_mem[4] = 32'hEEEE_EEEE;
        instr = 32'h0;
        drive_idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset state.
        check_val("rst_rdy", {31'd0, bus.hreadyout}, 32'd1);
        check_val("rst_resp", {31'd0, bus.hresp}, 32'd0);
        check_val("rst_data", bus.hrdata, 32'd0);
        check_val("rst_rom", {30'd0, sel_0, rd_en_rom}, 32'd0);
        check_val("rst_addr", address_rom, 32'd0);

        // Single read of word 1.
        do_read("rd4", 32'h4, 32'd1, 32'hBBBB_BBBB);

        // Back-to-back NONSEQ 0x0 then SEQ 0x8.
        drive(1'b1, 2'b10, 32'h0, 1'b0, 3'b010, 1'b1);
        step();
        drive(1'b1, 2'b11, 32'h8, 1'b0, 3'b010, 1'b0);
        check_val("b2b_w1_rdy", {31'd0, bus.hreadyout}, 32'd0);
        check_val("b2b_w1_addr", address_rom, 32'd0);
        check_val("b2b_w1_rden", {31'd0, rd_en_rom}, 32'd1);
        step();
        bus.hready = 1'b1;
        check_val("b2b_d1_rdy", {31'd0, bus.hreadyout}, 32'd1);
        check_val("b2b_d1_data", bus.hrdata, 32'hAAAA_AAAA);
        step();
        drive_idle();
        check_val("b2b_w2_rdy", {31'd0, bus.hreadyout}, 32'd0);
        check_val("b2b_w2_addr", address_rom, 32'd2);
        check_val("b2b_w2_rden", {31'd0, rd_en_rom}, 32'd1);
        step();
        check_val("b2b_d2_rdy", {31'd0, bus.hreadyout}, 32'd1);
        check_val("b2b_d2_data", bus.hrdata, 32'hCCCC_CCCC);
        step();
        check_val("b2b_idle_data", bus.hrdata, 32'd0);

        // Illegal transfers.
        do_err("err_wr", 32'h0, 1'b1, 3'b010);
        do_err("err_unal", 32'h2, 1'b0, 3'b010);
        do_err("err_byte", 32'h0, 1'b0, 3'b000);
        do_err("err_oor", 32'h14, 1'b0, 3'b010);
`ifdef AHB_ROM_ERR_CNT_EN
        check_val("err_count", {16'd0, err_count}, 32'd4);
`endif

        // IDLE, BUSY and deselected transfers.
        do_okay("ok_idle", 1'b1, 2'b00);
        do_okay("ok_busy", 1'b1, 2'b01);
        do_okay("ok_nosel", 1'b0, 2'b10);

        // Reset during RD_WAIT abandons the transfer.
        drive(1'b1, 2'b10, 32'hC, 1'b0, 3'b010, 1'b1);
        step();
        drive_idle();
        check_val("rstw_rden", {31'd0, rd_en_rom}, 32'd1);
        check_val("rstw_addr", address_rom, 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rstw_rdy", {31'd0, bus.hreadyout}, 32'd1);
        check_val("rstw_resp", {31'd0, bus.hresp}, 32'd0);
        check_val("rstw_data", bus.hrdata, 32'd0);
        check_val("rstw_rden0", {31'd0, rd_en_rom}, 32'd0);
        check_val("rstw_addr0", address_rom, 32'd0);
        do_read("rdC", 32'hC, 32'd3, 32'hDDDD_DDDD);

        // hready low stalls acceptance while in IDLE.
        drive(1'b1, 2'b10, 32'h10, 1'b0, 3'b010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("stall_rdy", {31'd0, bus.hreadyout}, 32'd1);
            check_val("stall_rom", {30'd0, sel_0, rd_en_rom}, 32'd0);
        end
        bus.hready = 1'b1;
        step();
        drive_idle();
        check_val("stall_acc_rdy", {31'd0, bus.hreadyout}, 32'd0);
        check_val("stall_acc_rden", {31'd0, rd_en_rom}, 32'd1);
        check_val("stall_acc_addr", address_rom, 32'd4);
        step();
        check_val("stall_data", bus.hrdata, 32'hEEEE_EEEE);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
